// File: rtl/datapath_core.sv
// Datapath stage: 8x16 register file, A/B operand registers, shifter, ALU,
// C result register and {V,N,Z} status register.
module datapath_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned IMMW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] datapath_in,
  input  logic             write,
  input  logic             vsel,
  input  logic             loada,
  input  logic             loadb,
  input  logic             asel,
  input  logic             bsel,
  input  logic             loadc,
  input  logic             loads,
  input  logic [2:0]       readnum,
  input  logic [2:0]       writenum,
  input  logic [1:0]       shift,
  input  logic [1:0]       ALUop,
  output logic [WIDTH-1:0] datapath_out,
  output logic [2:0]       status
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [2:0]       status_q;
  logic [WIDTH-1:0] sout, ain, bin, alu_out;
  logic             ovf;

  // Combinational read port; no bypass from a same-cycle write
  assign rd = regs[readnum];

  // Register file; write-back of C uses the pre-edge C value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= vsel ? datapath_in : c_q;
    end
  end

  // A/B operand registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (loada) a_q <= rd;
      if (loadb) b_q <= rd;
    end
  end

  // Shifter on B
  always_comb begin
    sout = b_q;
    case (shift)
      2'b01:   sout = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   sout = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   sout = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: sout = b_q;
    endcase
  end

  // Operand select: A may be forced to zero, B may take the zero-extended immediate
  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? WIDTH'(datapath_in[IMMW-1:0]) : sout;

  // ALU with signed-overflow detection for add/sub
  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_out = ain + bin;
        ovf     = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_out = ain - bin;
        ovf     = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  alu_out = ain & bin;
      OP_NOT:  alu_out = ~bin;
      default: alu_out = '0;
    endcase
  end

  // C result and {V,N,Z} status registers, independently enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q      <= '0;
      status_q <= 3'b000;
    end else begin
      if (loadc) c_q <= alu_out;
      if (loads) status_q <= {ovf, alu_out[WIDTH-1], (alu_out == '0)};
    end
  end

  assign datapath_out = c_q;
  assign status       = status_q;

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- Datapath stage directly downstream of the switch/control capture block.
- Consumes datapath_in plus the decoded control fields: write, vsel, loada, loadb, asel, bsel, loadc, loads, readnum, writenum, shift and ALUop.
- Contains an 8x16 register file, the A/B operand registers, a shifter, an ALU, the C result register and a 3-bit status register.
- Drives the result and status to the board display logic.

Parameters:
- WIDTH, 16, datapath word width.
- NREGS, 8, register-file depth; index width is 3.
- IMMW, 5, width of the immediate taken from datapath_in when bsel=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- datapath_in  in  16  external write data and immediate source.
- write  in  1  register-file write enable.
- vsel  in  1  write-data select: 1 = datapath_in, 0 = C.
- loada  in  1  load A from the register-file read port.
- loadb  in  1  load B from the register-file read port.
- asel  in  1  1 forces ALU operand A to 0.
- bsel  in  1  1 selects the zero-extended datapath_in[4:0] as ALU operand B.
- loadc  in  1  load C from the ALU result.
- loads  in  1  load the status register.
- readnum  in  3  read register index.
- writenum  in  3  write register index.
- shift  in  2  shifter op on B.
- ALUop  in  2  ALU op.
- datapath_out  out  16  C register.
- status  out  3  {V,N,Z}.

Behaviour:
- Reset (asynchronous, reset_n=0): R0..R7, A, B, C and status all clear to 0.
  - datapath_out=16'h0000, status=3'b000 while reset is held.
  - Synchronous actions resume on the first rising edge after release.
  - Reset asserted mid-sequence discards all state; there are no partial writes.
- Register file:
  - Read port is combinational: rd = R[readnum].
  - Write happens on the rising edge when write=1: R[writenum] <= vsel ? datapath_in : C.
  - C here is the pre-edge value, even when loadc=1 in the same cycle.
- Read/write collision: when write=1, writenum==readnum and loada or loadb=1 in the same cycle, A/B capture the OLD R value. There is no bypass.
- A and B registers: on the edge, A <= rd if loada; B <= rd if loadb. Otherwise both hold.
- Shifter on B, combinational, result sout:
  - 00: B unchanged.
  - 01: B<<1, LSB=0.
  - 10: B>>1 logical, MSB=0.
  - 11: B>>1 arithmetic, MSB=B[15].
- Operand select:
  - Ain = asel ? 0 : A.
  - Bin = bsel ? {11'b0, datapath_in[4:0]} : sout.
- ALU (16-bit, wraps modulo 2^16, no carry out):
  - 00: Ain+Bin.
  - 01: Ain-Bin.
  - 10: Ain&Bin.
  - 11: ~Bin.
- C register: C <= alu_out on the edge when loadc=1.
- Status register, loaded on the edge when loads=1, computed from the same-cycle alu_out:
  - Z = (alu_out==0).
  - N = alu_out[15].
  - V = signed overflow:
    - add: Ain[15]==Bin[15] && out[15]!=Ain[15].
    - sub: Ain[15]!=Bin[15] && out[15]!=Ain[15].
    - and / not: V=0.
- loads and loadc are independent; either may be asserted without the other.
- Latency:
  - Register → A/B: 1 edge.
  - A/B → C/status: 1 edge (shifter and ALU are combinational).
  - Full read-op-writeback sequence: 3 edges minimum.
- Index 0 is an ordinary register; it is not hardwired to zero.
- Any combination of load/write enables in one cycle is legal; each acts independently on the same edge.

Test Plan:
- Reset/init: pulse reset_n low mid-operation after writes → datapath_out=0, status=000, all R read 0.
- Write then read back:
  - Stimulus: write=1, vsel=1, datapath_in=16'h0007, writenum=0; then R1=16'h0002 likewise; then readnum=0 with loada, readnum=1 with loadb, shift=01, ALUop=00, loadc, loads.
  - Required: C=16'h000B (7+4), status=000.
  - Then vsel=0, writenum=2, write → R2=16'h000B.
- Sub/zero/negative:
  - A=5, B=5, ALUop=01, loads → Z=1, N=0.
  - A=3, B=5 → C=16'hFFFE, N=1, Z=0, V=0.
- Overflow:
  - A=16'h7FFF, B=1, add → C=16'h8000, V=1, N=1.
  - A=16'h8000, B=1, sub → C=16'h7FFF, V=1.
- Shifter/immediate:
  - B=16'h8002, shift=11, asel=1, ALUop=00 → C=16'hC001.
  - shift=10 → C=16'h4001.
  - bsel=1, datapath_in=16'hFFFF, A=1, add → C=16'h0020.
- Collision:
  - Same cycle: write R3 ← 16'h00AA with readnum=3 and loada=1, where R3 was 16'h0011 → A=16'h0011.
  - Next cycle's read of R3 → 16'h00AA.
  - Same cycle: write with vsel=0 and loadc → R gets the old C.
